// File: rtl/segment_display_arbiter.sv
// segment_display_arbiter: round-robin sharing of one 32-bit display word with a minimum dwell per grant
module segment_display_arbiter #(
  parameter int          NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [32*NUM_REQ-1:0] req_word,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [31:0]           hex_word,
  output logic                  display_valid,
  output logic                  busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, SHOW, ARB} state_t;
  state_t        state, nxt;
  logic [IW-1:0] last, win, idx;
  logic [31:0]   cnt, sel_word;
  logic          take, hold_end;
  always_comb begin
    win = last;
    idx = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (req[idx]) win = idx;
    end
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win == IW'(i)) sel_word = req_word[32*i +: 32];
  end
  always_comb begin
    hold_end = cnt == 32'(HOLD_CYCLES - 1);
    nxt = state;
    case (state)
      IDLE:    nxt = |req ? SHOW : IDLE;
      SHOW:    nxt = hold_end ? ARB : SHOW;
      default: nxt = |req ? SHOW : IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    take = state != SHOW && |req;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      last          <= IW'(NUM_REQ - 1);
      cnt           <= '0;
      gnt           <= '0;
      done          <= '0;
      hex_word      <= '0;
      display_valid <= 1'b0;
    end else begin
      state <= nxt;
      done  <= '0;
      if (take) begin
        gnt           <= NUM_REQ'(1) << win;
        hex_word      <= sel_word;
        display_valid <= 1'b1;
        last          <= win;
        cnt           <= '0;
      end else if (state == SHOW) begin
        cnt <= cnt + 32'd1;
        if (hold_end) begin
          gnt  <= '0;
          done <= gnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_segment_display_arbiter.sv
// tb_segment_display_arbiter: directed checks of grant order, dwell, done pulses and reset behaviour
module tb_segment_display_arbiter;
  logic         clk = 1'b0;
  logic         resetn, rn1;
  logic [3:0]   req, gnt, done, r1, g1, d1;
  logic [127:0] req_word, w1;
  logic [31:0]  hex_word, h1;
  logic         display_valid, busy, v1, b1;
  int           passed = 0, total = 0;

  always #5 clk = ~clk;

  segment_display_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_word(req_word), .gnt(gnt), .done(done),
    .hex_word(hex_word), .display_valid(display_valid), .busy(busy));

  segment_display_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .resetn(rn1), .req(r1), .req_word(w1), .gnt(g1), .done(d1),
    .hex_word(h1), .display_valid(v1), .busy(b1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; rn1 = 1'b0;
    req = 4'hF; r1 = 4'hF;
    req_word = {4{32'hCAFEF00D}}; w1 = req_word;
    repeat (3) tick;
    total++; if (gnt !== 4'b0) $display("FAIL reset_gnt: got %b want 0000", gnt); else passed++;
    total++; if (done !== 4'b0) $display("FAIL reset_done: got %b want 0000", done); else passed++;
    total++; if (hex_word !== 32'h0) $display("FAIL reset_hex: got %h want 00000000", hex_word); else passed++;
    total++; if (display_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", display_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    req = 4'b0;
    resetn = 1'b1;
    tick;
    total++; if (busy !== 1'b0 || gnt !== 4'b0) $display("FAIL idle_after_reset: got busy=%b gnt=%b want busy=0 gnt=0000", busy, gnt); else passed++;
  endtask

  task automatic test_single;
    req = 4'b0001;
    req_word[31:0] = 32'h12345678;
    tick;
    total++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", gnt); else passed++;
    total++; if (hex_word !== 32'h12345678) $display("FAIL single_hex: got %h want 12345678", hex_word); else passed++;
    total++; if (display_valid !== 1'b1 || busy !== 1'b1) $display("FAIL single_flags: got valid=%b busy=%b want 1 1", display_valid, busy); else passed++;
    req = 4'b0;
    for (int c = 2; c <= 4; c++) begin
      tick;
      total++; if (gnt !== 4'b0001) $display("FAIL single_hold c%0d: got %b want 0001", c, gnt); else passed++;
    end
    tick;
    total++; if (gnt !== 4'b0 || done !== 4'b0001 || busy !== 1'b1) $display("FAIL single_arb: got gnt=%b done=%b busy=%b want 0000 0001 1", gnt, done, busy); else passed++;
    tick;
    total++; if (done !== 4'b0 || busy !== 1'b0) $display("FAIL single_idle: got done=%b busy=%b want 0000 0", done, busy); else passed++;
    total++; if (hex_word !== 32'h12345678 || display_valid !== 1'b1) $display("FAIL single_keep: got hex=%h valid=%b want 12345678 1", hex_word, display_valid); else passed++;
  endtask

  task automatic test_contention;
    logic [3:0] e;
    resetn = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) req_word[32*i +: 32] = 32'hA0 + 32'(i);
    req = 4'b1111;
    resetn = 1'b1;
    for (int g = 0; g < 5; g++) begin
      e = 4'b0001 << (g % 4);
      tick;
      total++; if (gnt !== e) $display("FAIL rr_gnt g%0d: got %b want %b", g, gnt, e); else passed++;
      total++; if (hex_word !== 32'hA0 + 32'(g % 4)) $display("FAIL rr_hex g%0d: got %h want %h", g, hex_word, 32'hA0 + 32'(g % 4)); else passed++;
      repeat (3) tick;
      total++; if (gnt !== e) $display("FAIL rr_hold g%0d: got %b want %b", g, gnt, e); else passed++;
      tick;
      total++; if (gnt !== 4'b0 || done !== e) $display("FAIL rr_done g%0d: got gnt=%b done=%b want 0000 %b", g, gnt, done, e); else passed++;
    end
    req = 4'b0;
    tick;
  endtask

  task automatic test_dwell;
    req = 4'b0100;
    req_word[95:64] = 32'h22222222;
    tick;
    total++; if (gnt !== 4'b0100 || hex_word !== 32'h22222222) $display("FAIL dwell_grant: got gnt=%b hex=%h want 0100 22222222", gnt, hex_word); else passed++;
    req_word[95:64] = 32'hDEADBEEF;
    tick;
    req = 4'b0;
    for (int c = 2; c <= 4; c++) begin
      total++; if (gnt !== 4'b0100 || hex_word !== 32'h22222222) $display("FAIL dwell_hold c%0d: got gnt=%b hex=%h want 0100 22222222", c, gnt, hex_word); else passed++;
      if (c < 4) tick;
    end
    tick;
    total++; if (done !== 4'b0100 || hex_word !== 32'h22222222) $display("FAIL dwell_done: got done=%b hex=%h want 0100 22222222", done, hex_word); else passed++;
    tick;
  endtask

  task automatic test_reset_mid;
    req = 4'b0010;
    req_word[63:32] = 32'h55AA55AA;
    repeat (3) tick;
    total++; if (gnt !== 4'b0010 || hex_word !== 32'h55AA55AA) $display("FAIL mid_pre: got gnt=%b hex=%h want 0010 55aa55aa", gnt, hex_word); else passed++;
    resetn = 1'b0;
    req = 4'b0;
    tick;
    total++; if (gnt !== 4'b0 || hex_word !== 32'h0 || done !== 4'b0) $display("FAIL mid_reset: got gnt=%b hex=%h done=%b want 0000 0 0000", gnt, hex_word, done); else passed++;
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      total++; if (done !== 4'b0 || gnt !== 4'b0) $display("FAIL mid_nodone c%0d: got done=%b gnt=%b want 0000 0000", c, done, gnt); else passed++;
    end
  endtask

  task automatic test_hold1;
    logic [3:0] eg [6];
    logic [3:0] ed [6];
    eg = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
    ed = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
    r1 = 4'b0;
    tick;
    rn1 = 1'b1;
    w1[31:0] = 32'h11; w1[63:32] = 32'h22;
    r1 = 4'b0011;
    for (int c = 0; c < 6; c++) begin
      tick;
      total++; if (g1 !== eg[c] || d1 !== ed[c]) $display("FAIL hold1 c%0d: got gnt=%b done=%b want %b %b", c, g1, d1, eg[c], ed[c]); else passed++;
    end
    total++; if (h1 !== 32'h11) $display("FAIL hold1_hex: got %h want 00000011", h1); else passed++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_dwell;
    test_reset_mid;
    test_hold1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
